// File: rtl/demux_buffered.sv
// demux_buffered: index-directed elastic demultiplexer.
// One {index, data} token pair is consumed per cycle and its data is written into
// the one-entry registered slot of output[index]. An index >= SIZE consumes and
// drops the pair. Each output slot is independent, so only the slot addressed by
// the head token can stall the input.
// Optional feature: define DEMUX_TOKEN_COUNT_EN to add the tok_count port. It holds one
// saturating delivered-token counter per output.
module demux_buffered #(
    parameter int SIZE        = 2,
    parameter int DATA_TYPE   = 64,
    parameter int SELECT_TYPE = 1,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [SELECT_TYPE-1:0]    index,
    input  logic                      index_valid,
    output logic                      index_ready,
    input  logic [DATA_TYPE-1:0]      ins,
    input  logic                      ins_valid,
    output logic                      ins_ready,
    output logic [SIZE*DATA_TYPE-1:0] outs,
    output logic [SIZE-1:0]           outs_valid,
    input  logic [SIZE-1:0]           outs_ready
`ifdef DEMUX_TOKEN_COUNT_EN
    ,
    output logic [SIZE*CNT_WIDTH-1:0] tok_count
`endif
);

    // SIZE fits in SELECT_TYPE+1 bits because 2**SELECT_TYPE >= SIZE.
    localparam logic [SELECT_TYPE:0] SIZE_EXT = (SELECT_TYPE + 1)'(SIZE);

    // Reject parameter sets that cannot address every output.
    if (SIZE < 2 || (2 ** SELECT_TYPE) < SIZE || CNT_WIDTH < 1) begin : g_param_check
        $error("demux_buffered: illegal SIZE/SELECT_TYPE/CNT_WIDTH combination");
    end

    logic [SIZE-1:0] slot_free;
    logic            in_range;
    logic            sel_free;
    logic            fire;

    // Decide whether the head token pair can be consumed this cycle.
    // rst is part of the condition, so no token is taken while reset is asserted.
    always_comb begin
        in_range = ({1'b0, index} < SIZE_EXT);
        sel_free = 1'b0;
        for (int i = 0; i < SIZE; i++) begin
            if (index == SELECT_TYPE'(i)) begin
                sel_free = slot_free[i];
            end
        end
        fire = rst & index_valid & ins_valid & (~in_range | sel_free);
    end

    assign index_ready = fire;
    assign ins_ready   = fire;

    for (genvar gi = 0; gi < SIZE; gi++) begin : g_slot
        logic                 load;
        logic                 valid_q;
        logic                 valid_d;
        logic [DATA_TYPE-1:0] data_q;
        logic [DATA_TYPE-1:0] data_d;

        // The slot can accept data when it is empty or its content drains this cycle.
        assign slot_free[gi] = ~valid_q | outs_ready[gi];

        // Load on a routed fire. A slot that is drained and not reloaded goes empty.
        // A stalled slot keeps its data.
        always_comb begin
            load    = fire & in_range & (index == SELECT_TYPE'(gi));
            valid_d = load | (valid_q & ~outs_ready[gi]);
            data_d  = load ? ins : data_q;
        end

        // Slot register. Reset empties the slot and clears its data.
        always_ff @(posedge clk) begin
            if (!rst) begin
                valid_q <= 1'b0;
                data_q  <= '0;
            end else begin
                valid_q <= valid_d;
                data_q  <= data_d;
            end
        end

        assign outs[gi*DATA_TYPE +: DATA_TYPE] = data_q;
        assign outs_valid[gi]                  = valid_q;

`ifdef DEMUX_TOKEN_COUNT_EN
        logic [CNT_WIDTH-1:0] cnt_q;
        logic [CNT_WIDTH-1:0] cnt_d;

        // Count delivered tokens on this output. The count holds at its maximum value.
        always_comb begin
            cnt_d = cnt_q;
            if (valid_q && outs_ready[gi] && !(&cnt_q)) begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end

        // Counter register.
        always_ff @(posedge clk) begin
            if (!rst) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign tok_count[gi*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
`endif
    end

endmodule

// File: tb/tb_demux_buffered.sv
// Directed bench for demux_buffered. It drives a 2-output 64-bit instance from a
// vector table, then streams tokens through it against a scoreboard. It also drives
// a 3-output instance for out-of-range tokens and, when DEMUX_TOKEN_COUNT_EN is
// defined, checks that the token counter saturates.
module tb_demux_buffered;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance: SIZE=2, DATA_TYPE=64.
    logic         rst;
    logic [0:0]   index;
    logic         index_valid, index_ready;
    logic [63:0]  ins;
    logic         ins_valid, ins_ready;
    logic [127:0] outs;
    logic [1:0]   outs_valid, outs_ready;
`ifdef DEMUX_TOKEN_COUNT_EN
    logic [31:0]  tok_count;
`endif

    demux_buffered #(.SIZE(2), .DATA_TYPE(64), .SELECT_TYPE(1), .CNT_WIDTH(16)) u_dut (
        .clk(clk), .rst(rst), .index(index), .index_valid(index_valid),
        .index_ready(index_ready), .ins(ins), .ins_valid(ins_valid),
        .ins_ready(ins_ready), .outs(outs), .outs_valid(outs_valid),
        .outs_ready(outs_ready)
`ifdef DEMUX_TOKEN_COUNT_EN
        , .tok_count(tok_count)
`endif
    );

    // Second instance: SIZE=3, SELECT_TYPE=2, so index 3 is out of range.
    logic         t3_rst;
    logic [1:0]   t3_index;
    logic         t3_index_valid, t3_index_ready;
    logic [7:0]   t3_ins;
    logic         t3_ins_valid, t3_ins_ready;
    logic [23:0]  t3_outs;
    logic [2:0]   t3_outs_valid, t3_outs_ready;
`ifdef DEMUX_TOKEN_COUNT_EN
    logic [5:0]   t3_tok_count;
`endif

    demux_buffered #(.SIZE(3), .DATA_TYPE(8), .SELECT_TYPE(2), .CNT_WIDTH(2)) u_dut3 (
        .clk(clk), .rst(t3_rst), .index(t3_index), .index_valid(t3_index_valid),
        .index_ready(t3_index_ready), .ins(t3_ins), .ins_valid(t3_ins_valid),
        .ins_ready(t3_ins_ready), .outs(t3_outs), .outs_valid(t3_outs_valid),
        .outs_ready(t3_outs_ready)
`ifdef DEMUX_TOKEN_COUNT_EN
        , .tok_count(t3_tok_count)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic [0:0]  idx;
        logic        iv;
        logic        dv;
        logic [63:0] din;
        logic [1:0]  ordy;
        logic        exp_rdy;
        logic [1:0]  exp_ov;
        logic [63:0] exp_o0;
        logic [63:0] exp_o1;
    } vec_t;

    function automatic vec_t mk(logic r, logic [0:0] i, logic iv, logic dv, logic [63:0] d,
                                logic [1:0] o, logic er, logic [1:0] eov,
                                logic [63:0] e0, logic [63:0] e1);
        vec_t v;
        v.rst = r; v.idx = i; v.iv = iv; v.dv = dv; v.din = d; v.ordy = o;
        v.exp_rdy = er; v.exp_ov = eov; v.exp_o0 = e0; v.exp_o1 = e1;
        return v;
    endfunction

    localparam int NV = 16;
    vec_t vt [NV];

    logic [63:0] q0[$];
    logic [63:0] q1[$];

    initial begin
        int sent;
        int cyc;
        logic [63:0] exp_v;

        rst = 1'b0; index = '0; index_valid = 1'b1; ins = 64'h11; ins_valid = 1'b1;
        outs_ready = 2'b11;
        t3_rst = 1'b0; t3_index = '0; t3_index_valid = 1'b0; t3_ins = '0;
        t3_ins_valid = 1'b0; t3_outs_ready = 3'b000;

        // Fields: rst idx iv dv din ordy | exp_rdy exp_ov exp_o0 exp_o1
        vt[0]  = mk(0, 0, 1, 1, 64'h11,   2'b11, 0, 2'b00, 64'h0,  64'h0);    // reset, stimuli active
        vt[1]  = mk(0, 0, 1, 1, 64'h11,   2'b11, 0, 2'b00, 64'h0,  64'h0);
        vt[2]  = mk(1, 1, 1, 1, 64'hDEAD, 2'b11, 1, 2'b10, 64'h0,  64'hDEAD); // routing
        vt[3]  = mk(1, 0, 0, 0, 64'h0,    2'b11, 0, 2'b00, 64'h0,  64'hDEAD); // drain
        vt[4]  = mk(1, 0, 1, 1, 64'h5,    2'b10, 1, 2'b01, 64'h5,  64'hDEAD); // backpressure
        vt[5]  = mk(1, 0, 1, 1, 64'h6,    2'b10, 0, 2'b01, 64'h5,  64'hDEAD);
        vt[6]  = mk(1, 0, 1, 1, 64'h6,    2'b11, 1, 2'b01, 64'h6,  64'hDEAD); // drain+reload
        vt[7]  = mk(1, 0, 0, 0, 64'h0,    2'b10, 0, 2'b01, 64'h6,  64'hDEAD);
        vt[8]  = mk(1, 1, 1, 1, 64'h21,   2'b10, 1, 2'b11, 64'h6,  64'h21);   // bypass stalled slot 0
        vt[9]  = mk(1, 1, 1, 1, 64'h22,   2'b00, 0, 2'b11, 64'h6,  64'h21);
        vt[10] = mk(1, 1, 1, 0, 64'h22,   2'b11, 0, 2'b00, 64'h6,  64'h21);   // index alone
        vt[11] = mk(1, 1, 0, 1, 64'h22,   2'b11, 0, 2'b00, 64'h6,  64'h21);   // data alone
        vt[12] = mk(1, 0, 1, 1, 64'h30,   2'b11, 1, 2'b01, 64'h30, 64'h21);
        vt[13] = mk(1, 0, 1, 1, 64'h31,   2'b11, 1, 2'b01, 64'h31, 64'h21);
        vt[14] = mk(1, 1, 1, 1, 64'h40,   2'b11, 1, 2'b10, 64'h31, 64'h40);
        vt[15] = mk(0, 0, 1, 1, 64'h50,   2'b00, 0, 2'b00, 64'h0,  64'h0);    // reset mid-flight

        for (int v = 0; v < NV; v++) begin
            @(negedge clk);
            rst = vt[v].rst; index = vt[v].idx; index_valid = vt[v].iv;
            ins_valid = vt[v].dv; ins = vt[v].din; outs_ready = vt[v].ordy;
            t3_rst = vt[v].rst;
            #1;
            chk($sformatf("vec%0d index_ready", v), {63'b0, index_ready}, {63'b0, vt[v].exp_rdy});
            chk($sformatf("vec%0d ins_ready", v), {63'b0, ins_ready}, {63'b0, vt[v].exp_rdy});
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d outs_valid", v), {62'b0, outs_valid}, {62'b0, vt[v].exp_ov});
            chk($sformatf("vec%0d outs0", v), outs[63:0], vt[v].exp_o0);
            chk($sformatf("vec%0d outs1", v), outs[127:64], vt[v].exp_o1);
`ifdef DEMUX_TOKEN_COUNT_EN
            if (v == 1) chk("tok_count after reset", {32'b0, tok_count}, 64'h0);
`endif
            $display("[TB] vec %0d applied: idx=%0d data=%0h ov=%b", v, vt[v].idx, vt[v].din, outs_valid);
        end

        // Streaming: 100 tokens alternating between outputs. The first 20 use all-ready
        // outputs and must be taken 1 per cycle. The rest use random backpressure and valids.
        sent = 0;
        cyc  = 0;
        t3_rst = 1'b1;
        while (sent < 100 && cyc < 3000) begin
            @(negedge clk);
            rst = 1'b1;
            index = sent[0];
            ins = 64'h1000 + 64'(sent);
            if (sent < 20) begin
                index_valid = 1'b1; ins_valid = 1'b1; outs_ready = 2'b11;
            end else begin
                index_valid = ($urandom_range(0, 3) != 0);
                ins_valid = index_valid;
                outs_ready = 2'($urandom_range(0, 3));
            end
            #1;
            if (sent < 20) chk($sformatf("stream full-rate ready tok%0d", sent), {63'b0, ins_ready}, 64'h1);
            if (outs_valid[0] && outs_ready[0]) begin
                exp_v = (q0.size() > 0) ? q0.pop_front() : 64'hBAD0;
                chk("stream out0 order", outs[63:0], exp_v);
            end
            if (outs_valid[1] && outs_ready[1]) begin
                exp_v = (q1.size() > 0) ? q1.pop_front() : 64'hBAD1;
                chk("stream out1 order", outs[127:64], exp_v);
            end
            if (ins_ready) begin
                if (index == 1'b0) q0.push_back(ins); else q1.push_back(ins);
                $display("[TB] stream token %0d accepted to out%0d", sent, index);
                sent++;
            end
            cyc++;
        end
        chk("stream all tokens sent", 64'(sent), 64'd100);

        // Drain whatever is left in the slots.
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            index_valid = 1'b0; ins_valid = 1'b0; outs_ready = 2'b11;
            #1;
            if (outs_valid[0]) begin
                exp_v = (q0.size() > 0) ? q0.pop_front() : 64'hBAD0;
                chk("drain out0", outs[63:0], exp_v);
            end
            if (outs_valid[1]) begin
                exp_v = (q1.size() > 0) ? q1.pop_front() : 64'hBAD1;
                chk("drain out1", outs[127:64], exp_v);
            end
        end
        @(negedge clk);
        chk("stream leftovers out0", 64'(q0.size()), 64'd0);
        chk("stream leftovers out1", 64'(q1.size()), 64'd0);
        chk("stream outs_valid empty", {62'b0, outs_valid}, 64'h0);

        // Out-of-range test on the 3-output instance. First fill slot 2 and stall it.
        @(negedge clk);
        t3_index = 2'd2; t3_index_valid = 1'b1; t3_ins_valid = 1'b1; t3_ins = 8'hA2;
        t3_outs_ready = 3'b000;
        #1 chk("t3 slot2 load ready", {63'b0, t3_ins_ready}, 64'h1);
        @(posedge clk);
        #1;
        chk("t3 slot2 valid", {61'b0, t3_outs_valid}, 64'h4);
        chk("t3 slot2 data", {40'b0, t3_outs}, 64'hA20000);

        @(negedge clk);
        t3_index = 2'd3; t3_ins = 8'hEE;
        #1;
        chk("t3 oor index_ready", {63'b0, t3_index_ready}, 64'h1);
        chk("t3 oor ins_ready", {63'b0, t3_ins_ready}, 64'h1);
        @(posedge clk);
        #1;
        chk("t3 oor outs_valid", {61'b0, t3_outs_valid}, 64'h4);
        chk("t3 oor outs", {40'b0, t3_outs}, 64'hA20000);
`ifdef DEMUX_TOKEN_COUNT_EN
        chk("t3 oor tok_count", {58'b0, t3_tok_count}, 64'h0);
`endif
        $display("[TB] t3 out-of-range token dropped");

        // Send five tokens to output 0 with the output ready. Slot 2 stays stalled.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            t3_index = 2'd0; t3_ins = 8'(k + 1); t3_outs_ready = 3'b001;
            #1 chk($sformatf("t3 stream0 ready tok%0d", k), {63'b0, t3_ins_ready}, 64'h1);
            @(posedge clk);
            #1 chk($sformatf("t3 stream0 data tok%0d", k), {56'b0, t3_outs[7:0]}, 64'(k + 1));
            $display("[TB] t3 token %0d to out0", k);
        end
        @(negedge clk);
        t3_index_valid = 1'b0; t3_ins_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("t3 after drain outs_valid", {61'b0, t3_outs_valid}, 64'h4);
`ifdef DEMUX_TOKEN_COUNT_EN
        chk("t3 tok_count saturated", {58'b0, t3_tok_count}, 64'h3);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
